// File: rtl/mlp_pkg.sv
`default_nettype none
// mlp_pkg: shared widths, sequencer state type and ReLU helper for the MLP neuron sequencer.
// Revision: 1.0
package mlp_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int DW        = 4;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_MAC  = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  // ReLU gate on a two's-complement value: it passes only when the sign bit is clear, so zero stays zero.
  function automatic logic relu_pass(input logic sign_bit);
    return !sign_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_relu_unit.sv
`default_nettype none
// mac_relu_unit: combinational signed 4b x 4b multiply, accumulate onto t_i, plus ReLU of the sum.
// Revision: 1.0
module mac_relu_unit
  import mlp_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] t_i,
  input  logic [DW-1:0]    i_i,
  input  logic [DW-1:0]    w_i,
  output logic [ACC_W-1:0] total_o,
  output logic [ACC_W-1:0] relu_o
);

  logic signed [2*DW-1:0] prod;

  // Operands are widened to the product width so the multiply is exact without relying on context sizing.
  assign prod    = $signed({{DW{i_i[DW-1]}}, i_i}) * $signed({{DW{w_i[DW-1]}}, w_i});
  assign total_o = t_i + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign relu_o  = relu_pass(total_o[ACC_W-1]) ? total_o : '0;

endmodule
`default_nettype wire

// File: rtl/mlp_neuron_seq.sv
`default_nettype none
// mlp_neuron_seq: time-shares one MAC/ReLU unit across NEURONS neurons; MLP_RAW_OUT_EN adds out_raw (pre-ReLU acc).
// Revision: 1.0
module mlp_neuron_seq
  import mlp_pkg::*;
#(
  parameter  int FAN_IN  = 4,
  parameter  int NEURONS = 4,
  parameter  int ACC_W   = ACC_W_DEF,
  localparam int AW      = $clog2(NEURONS*FAN_IN),
  localparam int NW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [DW-1:0]    cfg_wdata,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [NW-1:0]    out_idx,
`ifdef MLP_RAW_OUT_EN
  output logic [ACC_W-1:0] out_raw,
`endif
  output logic             busy
);

  localparam int KW  = $clog2(FAN_IN);
  localparam int NWT = NEURONS * FAN_IN;

  state_e           state_q, state_d;
  logic [KW-1:0]    in_cnt_q, in_cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic [NW-1:0]    neuron_q, neuron_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [DW-1:0]    w_mem_q [NWT];
  logic [DW-1:0]    in_buf_q [FAN_IN];

  logic [ACC_W-1:0] mac_total, mac_relu;
  logic [AW-1:0]    w_raddr;
  logic             in_fire, cfg_fire, mac_last;

  assign in_ready  = rst_n && (state_q == S_FILL);
  assign in_fire   = in_valid && in_ready;
  // Weights only change while idle so a vector in flight always sees one consistent weight set.
  assign cfg_fire  = cfg_we && (state_q == S_FILL) && (int'(cfg_addr) < NWT);
  assign mac_last  = (state_q == S_MAC) && (k_q == KW'(FAN_IN-1));
  assign w_raddr   = AW'(int'(neuron_q) * FAN_IN + int'(k_q));

  assign out_valid = (state_q == S_EMIT);
  assign busy      = (state_q != S_FILL);
  assign out_data  = out_data_q;
  assign out_idx   = neuron_q;

  mac_relu_unit #(
    .ACC_W (ACC_W)
  ) u_mac (
    .t_i     (acc_q),
    .i_i     (in_buf_q[k_q]),
    .w_i     (w_mem_q[w_raddr]),
    .total_o (mac_total),
    .relu_o  (mac_relu)
  );

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    k_d        = k_q;
    neuron_d   = neuron_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    unique case (state_q)
      S_FILL: begin
        if (in_fire) begin
          if (in_cnt_q == KW'(FAN_IN-1)) begin
            state_d  = S_MAC;
            in_cnt_d = '0;
            k_d      = '0;
            neuron_d = '0;
            acc_d    = '0;
          end else begin
            in_cnt_d = in_cnt_q + KW'(1);
          end
        end
      end
      S_MAC: begin
        acc_d = mac_total;
        if (mac_last) begin
          state_d    = S_EMIT;
          out_data_d = mac_relu;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (neuron_q == NW'(NEURONS-1)) begin
            state_d = S_FILL;
          end else begin
            neuron_d = neuron_q + NW'(1);
            k_d      = '0;
            acc_d    = '0;
            state_d  = S_MAC;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      in_cnt_q   <= '0;
      k_q        <= '0;
      neuron_q   <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      for (int j = 0; j < NWT; j++) begin
        w_mem_q[j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      k_q        <= k_d;
      neuron_q   <= neuron_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      if (cfg_fire) begin
        w_mem_q[cfg_addr] <= cfg_wdata;
      end
    end
  end

  // Pure datapath storage: a stale vector is never read because in_cnt restarts at zero.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      in_buf_q[in_cnt_q] <= in_data;
    end
  end

`ifdef MLP_RAW_OUT_EN
  logic [ACC_W-1:0] out_raw_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_raw_q <= '0;
    end else if (mac_last) begin
      out_raw_q <= mac_total;
    end
  end

  assign out_raw = out_raw_q;
`endif

endmodule
`default_nettype wire
